// File: rtl/vpu_alu_div_seq_pkg.sv
// rtl/vpu_alu_div_seq_pkg.sv - shared types and defaults for the vector divide sequencer
package vpu_alu_div_seq_pkg;

    localparam int DIV_DATA_WIDTH = 16;
    localparam int DIV_LANES      = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } div_seq_state_t;

    // Lane index width, never narrower than one bit so single-lane builds still have a counter.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vpu_alu_div_iter.sv
// rtl/vpu_alu_div_iter.sv - one-lane restoring divider step datapath
module vpu_alu_div_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next,
    output logic                  last
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] div;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH:0]   trial;
    logic                  fits;

    // The trial value keeps the full remainder so divisors above half range stay exact.
    always_comb begin
        trial    = {rem, quo[DATA_WIDTH-1]};
        fits     = trial >= {1'b0, div};
        rem_next = fits ? DATA_WIDTH'(trial - {1'b0, div}) : trial[DATA_WIDTH-1:0];
        quo_next = {quo[DATA_WIDTH-2:0], fits};
    end

    assign last = (bit_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            div     <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            rem     <= '0;
            quo     <= '0;
            div     <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            rem     <= '0;
            quo     <= dividend;
            div     <= divisor;
            bit_cnt <= CNT_W'(DATA_WIDTH - 1);
        end else if (step) begin
            rem     <= rem_next;
            quo     <= quo_next;
            bit_cnt <= bit_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/vpu_alu_div_seq.sv
// rtl/vpu_alu_div_seq.sv - shares one iterative divider across all vector lanes
module vpu_alu_div_seq
    import vpu_alu_div_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int LANES      = DIV_LANES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        rem_sel,
    input  logic [LANES*DATA_WIDTH-1:0] op_0,
    input  logic [LANES*DATA_WIDTH-1:0] op_1,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] result_o,
    output logic [LANES-1:0]            dz_o,
    output logic                        busy_o
);

    localparam int                LANE_W    = lane_w(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    div_seq_state_t              state;
    logic [LANE_W-1:0]           lane;
    logic [LANES*DATA_WIDTH-1:0] dividends;
    logic [LANES*DATA_WIDTH-1:0] divisors;
    logic                        rem_sel_q;
    logic [DATA_WIDTH-1:0]       lane_dividend;
    logic [DATA_WIDTH-1:0]       lane_divisor;
    logic [DATA_WIDTH-1:0]       rem_next;
    logic [DATA_WIDTH-1:0]       quo_next;
    logic [DATA_WIDTH-1:0]       lane_result;
    logic                        last;
    logic                        load_en;
    logic                        step_en;

    assign lane_dividend = dividends[lane*DATA_WIDTH +: DATA_WIDTH];
    assign lane_divisor  = divisors[lane*DATA_WIDTH +: DATA_WIDTH];
    assign load_en       = (state == LOAD);
    assign step_en       = (state == ITER);

    // Zero divisor: remainder mode returns the dividend, quotient mode saturates to all ones.
    always_comb begin
        if (dz_o[lane]) begin
            lane_result = rem_sel_q ? lane_dividend : '1;
        end else begin
            lane_result = rem_sel_q ? rem_next : quo_next;
        end
    end

    vpu_alu_div_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .load     (load_en),
        .step     (step_en),
        .dividend (lane_dividend),
        .divisor  (lane_divisor),
        .rem_next (rem_next),
        .quo_next (quo_next),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane      <= '0;
            dividends <= '0;
            divisors  <= '0;
            rem_sel_q <= 1'b0;
            result_o  <= '0;
            dz_o      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            lane      <= '0;
            result_o  <= '0;
            dz_o      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dividends <= op_0;
                        divisors  <= op_1;
                        rem_sel_q <= rem_sel;
                        result_o  <= '0;
                        dz_o      <= '0;
                        lane      <= '0;
                        in_ready  <= 1'b0;
                        busy_o    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (lane_divisor == '0) begin
                        dz_o[lane] <= 1'b1;
                    end
                    state <= ITER;
                end
                ITER: begin
                    if (last) begin
                        result_o[lane*DATA_WIDTH +: DATA_WIDTH] <= lane_result;
                        if (lane == LAST_LANE) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            lane  <= lane + LANE_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_alu_div_seq.sv
// tb/tb_vpu_alu_div_seq.sv - scoreboard bench for the vector divide sequencer
module tb_vpu_alu_div_seq;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int VW = W * L;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          rem_sel;
    logic [VW-1:0] op_0;
    logic [VW-1:0] op_1;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] result_o;
    logic [L-1:0]  dz_o;
    logic          busy_o;

    typedef struct {
        logic [VW-1:0] res;
        logic [L-1:0]  dz;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   prev_acc = -1;
    bit   thru_chk = 0;
    bit   seen = 0;

    localparam logic [VW-1:0] V1A = {16'd100, 16'd7, 16'd65535, 16'd0};
    localparam logic [VW-1:0] V1B = {16'd7, 16'd7, 16'd1, 16'd5};
    localparam logic [VW-1:0] V2A = {16'd100, 16'd1234, 16'd65535, 16'd0};
    localparam logic [VW-1:0] V2B = {16'd7, 16'd0, 16'd1, 16'd5};
    localparam logic [VW-1:0] V1Q = {16'd14, 16'd1, 16'd65535, 16'd0};
    localparam logic [VW-1:0] V1R = {16'd2, 16'd0, 16'd0, 16'd0};
    localparam logic [VW-1:0] V2Q = {16'd14, 16'hFFFF, 16'd65535, 16'd0};
    localparam logic [VW-1:0] V2R = {16'd2, 16'd1234, 16'd0, 16'd0};

    vpu_alu_div_seq #(
        .DATA_WIDTH(W),
        .LANES     (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rem_sel   (rem_sel),
        .op_0      (op_0),
        .op_1      (op_1),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .dz_o      (dz_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic rs,
                                  output logic [VW-1:0] r, output logic [L-1:0] d);
        logic [W-1:0] x;
        logic [W-1:0] y;
        r = '0;
        d = '0;
        for (int i = 0; i < L; i++) begin
            x = a[i*W +: W];
            y = b[i*W +: W];
            if (y == 0) begin
                d[i] = 1'b1;
                r[i*W +: W] = rs ? x : 16'hFFFF;
            end else begin
                r[i*W +: W] = rs ? (x % y) : (x / y);
            end
        end
    endfunction

    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic rs,
                        input logic [VW-1:0] er, input logic [L-1:0] ed);
        int n = 0;
        exp_t e;
        @(posedge clk); #1;
        op_0 = a;
        op_1 = b;
        rem_sel = rs;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            if (thru_chk && prev_acc >= 0) chk("throughput", VW'(cyc - prev_acc), VW'(70));
            prev_acc = cyc;
            e.res = er;
            e.dz  = ed;
            e.acc = cyc;
            q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", VW'(q.size()), '0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, VW'(in_ready), VW'(1));
        chk({tag, "_out_valid"}, VW'(out_valid), '0);
        chk({tag, "_busy"}, VW'(busy_o), '0);
        chk({tag, "_result"}, result_o, '0);
        chk({tag, "_dz"}, VW'(dz_o), '0);
    endtask

    // Monitor: latency on the first visible out_valid, data on the handshake cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_out_valid: got result %0h with nothing outstanding", result_o);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", VW'(cyc - q[0].acc), VW'(69));
                    end
                    if (out_ready) begin
                        chk("result", result_o, q[0].res);
                        chk("dz", VW'(dz_o), VW'(q[0].dz));
                        q.delete(0);
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] r;
        logic [L-1:0]  d;
        logic          rs;
        int            n;

        rst_n = 1'b0;
        in_valid = 1'b0;
        rem_sel = 1'b0;
        op_0 = '0;
        op_1 = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;

        send(V1A, V1B, 1'b0, V1Q, 4'b0000); drain();
        send(V1A, V1B, 1'b1, V1R, 4'b0000); drain();
        send(V2A, V2B, 1'b0, V2Q, 4'b0100); drain();
        send(V2A, V2B, 1'b1, V2R, 4'b0100); drain();

        // Destination stalls for 10 cycles while junk input is offered.
        out_ready = 1'b0;
        send(V1A, V1B, 1'b0, V1Q, 4'b0000);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_rise", VW'(out_valid), VW'(1));
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_0 = '1;
            op_1 = '1;
            @(posedge clk); #1;
            chk("stall_valid", VW'(out_valid), VW'(1));
            chk("stall_result", result_o, V1Q);
            chk("stall_dz", VW'(dz_o), '0);
            chk("stall_in_ready", VW'(in_ready), '0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Flush 30 cycles into an operation, then a clean vector.
        send(V2A, V2B, 1'b0, V2Q, 4'b0100);
        repeat (29) @(posedge clk);
        #1;
        flush = 1'b1;
        q.delete(q.size() - 1);
        seen = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk_idle("flush");
        send(V2A, V2B, 1'b1, V2R, 4'b0100); drain();

        // Asynchronous reset during ITER.
        send(V1A, V1B, 1'b1, V1R, 4'b0000);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete(q.size() - 1);
        seen = 1'b0;
        #1;
        chk_idle("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(V2A, V2B, 1'b0, V2Q, 4'b0100); drain();

        // Random back-to-back vectors against a / and % model.
        thru_chk = 1'b1;
        prev_acc = -1;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < L; i++) begin
                a[i*W +: W] = W'($urandom);
                case ($urandom_range(0, 3))
                    0:       b[i*W +: W] = '0;
                    1:       b[i*W +: W] = W'($urandom_range(1, 15));
                    default: b[i*W +: W] = W'($urandom);
                endcase
            end
            rs = 1'($urandom_range(0, 1));
            model(a, b, rs, r, d);
            send(a, b, rs, r, d);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
